// File: rtl/delta_pu_pkg.sv
// Shared types and constants for the delta PU weight-fetch path.
// Imported by the fetcher, its bus interface and the bench-facing top.
package delta_pu_pkg;

  localparam int FETCH_FIFO_DEPTH = 8;
  localparam int WEIGHT_WORD_W    = 32;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } fetch_state_e;

endpackage

// File: rtl/delta_pu_weight_fetcher_if.sv
// Weight-manager SRAM handshake plus the weight-queue pop port of one PU.
// The master side is the fetcher; the slave side is the weight manager and datapath.
interface delta_pu_weight_fetcher_if
  import delta_pu_pkg::*;
#(
  parameter int DATA_W = WEIGHT_WORD_W,
  parameter int ADDR_W = 32
);

  logic              WB_SRAM_read;
  logic [ADDR_W-1:0] WB_SRAM_address;
  logic              WB_SRAM_ready;
  logic [DATA_W-1:0] WB_SRAM_data;
  logic              wq_valid;
  logic [DATA_W-1:0] wq_data;
  logic              wq_last;
  logic              wq_pop;

  modport master (
    output WB_SRAM_read,
    output WB_SRAM_address,
    input  WB_SRAM_ready,
    input  WB_SRAM_data,
    output wq_valid,
    output wq_data,
    output wq_last,
    input  wq_pop
  );

  modport slave (
    input  WB_SRAM_read,
    input  WB_SRAM_address,
    output WB_SRAM_ready,
    output WB_SRAM_data,
    input  wq_valid,
    input  wq_data,
    input  wq_last,
    output wq_pop
  );

endinterface

// File: rtl/delta_sync_fifo.sv
// Small synchronous FIFO with a registered head; pushes when full and pops when
// empty are ignored. Shared by the weight queue and the input-delta queue.
module delta_sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/delta_pu_weight_fetcher.sv
// Per-PU weight fetcher: on start, reads word_count words from base_addr through
// the weight manager into a FIFO and raises finished once the burst has drained.
module delta_pu_weight_fetcher
  import delta_pu_pkg::*;
#(
  parameter int DATA_W     = WEIGHT_WORD_W,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = FETCH_FIFO_DEPTH,
  parameter int ADDR_STEP  = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [LEN_W-1:0]          word_count,
  delta_pu_weight_fetcher_if.master wb,
  output logic                      busy,
  output logic                      finished
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e      state;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  remaining;
  logic              busy_q;
  logic              finished_q;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_head;
  logic              read_req;
  logic              serve;

  assign read_req           = (state == FETCH) && !fifo_full;
  assign serve              = read_req && wb.WB_SRAM_ready;
  assign wb.WB_SRAM_read    = read_req;
  assign wb.WB_SRAM_address = addr_q;
  assign wb.wq_valid        = !fifo_empty;
  assign wb.wq_data         = fifo_head[DATA_W-1:0];
  assign wb.wq_last         = fifo_head[DATA_W];
  assign busy               = busy_q;
  assign finished           = finished_q;

  // Each entry carries a last-word tag alongside the weight word.
  delta_sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (serve),
    .push_data ({remaining == LEN_W'(1), wb.WB_SRAM_data}),
    .pop       (wb.wq_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Starts are only honoured in IDLE, so a start during any burst phase is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      remaining  <= '0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr_q     <= base_addr;
            remaining  <= word_count;
            finished_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= (word_count != '0) ? FETCH : DONE;
          end
        end
        FETCH: begin
          if (serve) begin
            addr_q    <= addr_q + ADDR_W'(ADDR_STEP);
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_count == '0) state <= DONE;
        end
        DONE: begin
          finished_q <= 1'b1;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A serve without an outstanding request is dropped by the datapath and flagged here.
  assert property (@(posedge clock) disable iff (reset) !(wb.WB_SRAM_ready && !read_req));

endmodule

// File: tb/tb_delta_pu_weight_fetcher.sv
// Randomised bench for delta_pu_weight_fetcher: a weight-manager responder and a
// queue consumer run on the falling edge; bursts are checked against address/word lists.
module tb_delta_pu_weight_fetcher;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  word_count = '0;
  logic              busy;
  logic              finished;

  delta_pu_weight_fetcher_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb ();

  delta_pu_weight_fetcher dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .wb         (wb.master),
    .busy       (busy),
    .finished   (finished)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  int          ready_mode = 0;
  int          pop_mode   = 0;
  int unsigned cyc        = 0;
  logic [31:0] tag        = 32'h0;

  logic [ADDR_W-1:0] served_q[$];
  int unsigned       served_cyc[$];
  logic [DATA_W:0]   popped_q[$];

  function automatic logic [31:0] word_of(logic [31:0] addr, logic [31:0] t);
    return (addr * 32'h9E3779B1) ^ t ^ 32'h5A5A0000;
  endfunction

  task automatic checkOutput(string name, logic [63:0] observed, logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, observed, expected);
    end
  endtask

  // Responder and consumer act on the falling edge so the DUT sees stable inputs.
  initial begin
    wb.WB_SRAM_ready = 1'b0;
    wb.WB_SRAM_data  = '0;
    wb.wq_pop        = 1'b0;
  end

  always @(negedge clock) begin
    bit gate;
    bit pop_now;
    cyc++;
    case (ready_mode)
      1:       gate = 1'b1;
      2:       gate = (cyc % 3 == 0);
      3:       gate = ($urandom_range(0, 1) == 1);
      default: gate = 1'b0;
    endcase
    wb.WB_SRAM_ready = wb.WB_SRAM_read && gate;
    wb.WB_SRAM_data  = wb.WB_SRAM_ready ? word_of(wb.WB_SRAM_address, tag) : $urandom;
    if (wb.WB_SRAM_ready) begin
      served_q.push_back(wb.WB_SRAM_address);
      served_cyc.push_back(cyc);
    end
    case (pop_mode)
      1:       pop_now = 1'b1;
      2:       pop_now = ($urandom_range(0, 2) != 0);
      default: pop_now = 1'b0;
    endcase
    wb.wq_pop = pop_now;
    if (pop_now && wb.wq_valid) popped_q.push_back({wb.wq_last, wb.wq_data});
  end

  task automatic tick(int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic newBurst(int rmode, int pmode);
    served_q.delete();
    served_cyc.delete();
    popped_q.delete();
    tag        = $urandom;
    ready_mode = rmode;
    pop_mode   = pmode;
  endtask

  task automatic applyStimulus(logic [ADDR_W-1:0] base, logic [LEN_W-1:0] n);
    base_addr  = base;
    word_count = n;
    start      = 1'b1;
    tick(1);
    start      = 1'b0;
  endtask

  task automatic waitFinished(int budget);
    for (int i = 0; i < budget; i++) begin
      if (finished) break;
      tick(1);
    end
    checkOutput("finished_within_budget", finished, 1);
  endtask

  // Expected burst: addresses base + 4*i, words word_of(address), last on the final word.
  task automatic compareBurst(string name, logic [ADDR_W-1:0] base, int n);
    checkOutput({name, "_served_count"}, served_q.size(), n);
    checkOutput({name, "_popped_count"}, popped_q.size(), n);
    for (int i = 0; i < n; i++) begin
      logic [ADDR_W-1:0] a;
      a = base + ADDR_W'(4 * i);
      if (i < served_q.size()) checkOutput({name, "_addr"}, served_q[i], a);
      if (i < popped_q.size()) begin
        checkOutput({name, "_data"}, popped_q[i][DATA_W-1:0], word_of(a, tag));
        checkOutput({name, "_last"}, popped_q[i][DATA_W], (i == n - 1));
      end
    end
    checkOutput({name, "_busy_after"}, busy, 0);
    checkOutput({name, "_valid_after"}, wb.wq_valid, 0);
  endtask

  initial begin
    logic [ADDR_W-1:0] base;
    int n;

    tick(2);
    checkOutput("reset_read", wb.WB_SRAM_read, 0);
    checkOutput("reset_addr", wb.WB_SRAM_address, 0);
    checkOutput("reset_valid", wb.wq_valid, 0);
    checkOutput("reset_last", wb.wq_last, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_finished", finished, 0);
    reset = 1'b0;
    tick(1);

    // Basic burst, ready and pop always high.
    newBurst(1, 1);
    applyStimulus(32'h100, 3);
    checkOutput("basic_start_read", wb.WB_SRAM_read, 1);
    checkOutput("basic_start_addr", wb.WB_SRAM_address, 32'h100);
    checkOutput("basic_start_busy", busy, 1);
    waitFinished(200);
    compareBurst("basic", 32'h100, 3);
    if (served_cyc.size() == 3)
      checkOutput("basic_back_to_back", served_cyc[2] - served_cyc[0], 2);
    tick(5);
    checkOutput("basic_finished_held", finished, 1);

    // Backpressure: FIFO fills to 8 then the request drops.
    newBurst(1, 0);
    base = $urandom & ~32'h3;
    applyStimulus(base, 12);
    tick(20);
    checkOutput("bp_served_8", served_q.size(), 8);
    checkOutput("bp_read_low", wb.WB_SRAM_read, 0);
    checkOutput("bp_addr_held", wb.WB_SRAM_address, base + 32'h20);
    checkOutput("bp_valid", wb.wq_valid, 1);
    checkOutput("bp_head", wb.wq_data, word_of(base, tag));
    checkOutput("bp_busy", busy, 1);
    pop_mode = 1;
    waitFinished(500);
    compareBurst("bp", base, 12);

    // Gappy ready: one serve every third cycle.
    newBurst(2, 2);
    applyStimulus(32'h300, 4);
    waitFinished(500);
    compareBurst("gappy", 32'h300, 4);
    for (int i = 0; i + 1 < served_cyc.size(); i++)
      checkOutput("gappy_spacing", served_cyc[i+1] - served_cyc[i], 3);

    // Zero-length burst.
    newBurst(1, 1);
    applyStimulus(32'h500, 0);
    checkOutput("zero_read_n1", wb.WB_SRAM_read, 0);
    checkOutput("zero_finished_n1", finished, 0);
    checkOutput("zero_busy_n1", busy, 1);
    tick(1);
    checkOutput("zero_finished_n2", finished, 1);
    checkOutput("zero_busy_n2", busy, 0);
    tick(3);
    checkOutput("zero_no_requests", served_q.size(), 0);
    checkOutput("zero_valid", wb.wq_valid, 0);

    // Reset during the second word of five, then a clean 2-word burst.
    newBurst(1, 0);
    applyStimulus(32'h400, 5);
    for (int i = 0; i < 50; i++) begin
      if (served_q.size() >= 2) break;
      tick(1);
    end
    checkOutput("rst_reached_word2", served_q.size(), 2);
    reset = 1'b1;
    tick(1);
    checkOutput("rst_read", wb.WB_SRAM_read, 0);
    checkOutput("rst_addr", wb.WB_SRAM_address, 0);
    checkOutput("rst_valid", wb.wq_valid, 0);
    checkOutput("rst_last", wb.wq_last, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_finished", finished, 0);
    reset = 1'b0;
    tick(1);
    newBurst(1, 1);
    applyStimulus(32'h400, 2);
    waitFinished(200);
    compareBurst("post_rst", 32'h400, 2);

    // Second start during a burst must be ignored.
    newBurst(2, 1);
    applyStimulus(32'h200, 6);
    tick(4);
    applyStimulus(32'h900, 3);
    waitFinished(500);
    compareBurst("start_busy", 32'h200, 6);

    // Random bursts with random ready and pop patterns.
    for (int b = 0; b < 6; b++) begin
      newBurst(3, 2);
      base = $urandom & ~32'h3;
      n    = $urandom_range(1, 20);
      applyStimulus(base, LEN_W'(n));
      waitFinished(2000);
      compareBurst("random", base, n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
